// File: rtl/rdma_meta_tx_drr_sched.sv
// rtl/rdma_meta_tx_drr_sched.sv - deficit-round-robin scheduler for the shared RDMA TX command port
// Define RDMA_TX_SCHED_STATS_EN to build the per-region grant counters on stat_cnt.
module rdma_meta_tx_drr_sched #(
   parameter  int N_REGIONS = 4,
   parameter  int DATA_BITS = 256,
   parameter  int LEN_BITS  = 32,
   parameter  int Q_BITS    = 16,
   localparam int VF_BITS   = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [N_REGIONS-1:0]          s_valid,
   output logic [N_REGIONS-1:0]          s_ready,
   input  logic [N_REGIONS*DATA_BITS-1:0] s_data,
   input  logic [N_REGIONS*LEN_BITS-1:0] s_len,
   input  logic [N_REGIONS*Q_BITS-1:0]   quantum,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_BITS-1:0]          m_data,
   output logic [VF_BITS-1:0]            m_vfid,
   output logic [N_REGIONS*32-1:0]       stat_cnt
);

   localparam int                 DEF_W   = LEN_BITS + 1;
   localparam logic [DEF_W-1:0]   DEF_MAX = '1;
   localparam logic [VF_BITS-1:0] LAST    = VF_BITS'(N_REGIONS - 1);

   typedef enum logic {
      ST_SELECT,
      ST_SERVE
   } state_e;

   state_e               state_q, state_d;
   logic [VF_BITS-1:0]   ptr_q, ptr_d, ptr_nxt;
   logic [DEF_W-1:0]     def_q [N_REGIONS];
   logic [DEF_W-1:0]     def_d [N_REGIONS];
   logic                 m_valid_q, m_valid_d;
   logic [DATA_BITS-1:0] m_data_q, m_data_d;
   logic [VF_BITS-1:0]   m_vfid_q, m_vfid_d;

   logic [DATA_BITS-1:0] data_a [N_REGIONS];
   logic [LEN_BITS-1:0]  len_a  [N_REGIONS];
   logic [Q_BITS-1:0]    q_a    [N_REGIONS];

   genvar g;
   generate
      for (g = 0; g < N_REGIONS; g++) begin : g_unpack
         assign data_a[g] = s_data[g*DATA_BITS +: DATA_BITS];
         assign len_a[g]  = s_len[g*LEN_BITS +: LEN_BITS];
         assign q_a[g]    = quantum[g*Q_BITS +: Q_BITS];
      end
   endgenerate

   logic                cur_valid;
   logic [LEN_BITS-1:0] cur_cost;
   logic [Q_BITS-1:0]   cur_q;
   logic [DEF_W-1:0]    cur_def;
   logic [DEF_W:0]      credit_sum;
   logic [DEF_W-1:0]    def_credit;
   logic                cost_ok;
   logic                out_free;
   logic                load;

   always_comb begin
      cur_valid  = s_valid[ptr_q];
      cur_q      = q_a[ptr_q];
      cur_def    = def_q[ptr_q];
      // zero-length commands still cost one byte so they cannot starve others
      cur_cost   = (len_a[ptr_q] == '0) ? LEN_BITS'(1) : len_a[ptr_q];
      credit_sum = {1'b0, cur_def} + (DEF_W+1)'(cur_q);
      def_credit = credit_sum[DEF_W] ? DEF_MAX : credit_sum[DEF_W-1:0];
      cost_ok    = ({1'b0, cur_cost} <= cur_def);
      out_free   = !m_valid_q || m_ready;
      ptr_nxt    = (ptr_q == LAST) ? '0 : ptr_q + VF_BITS'(1);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      def_d   = def_q;
      load    = 1'b0;
      case (state_q)
         ST_SELECT: begin
            if (!cur_valid || cur_q == '0) begin
               def_d[ptr_q] = '0;
               ptr_d        = ptr_nxt;
            end else begin
               def_d[ptr_q] = def_credit;
               state_d      = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (!cur_valid) begin
               def_d[ptr_q] = '0;
               ptr_d        = ptr_nxt;
               state_d      = ST_SELECT;
            end else if (!cost_ok) begin
               ptr_d   = ptr_nxt;
               state_d = ST_SELECT;
            end else if (out_free) begin
               load         = 1'b1;
               def_d[ptr_q] = cur_def - {1'b0, cur_cost};
            end
         end
         default: state_d = ST_SELECT;
      endcase
   end

   always_comb begin
      s_ready = '0;
      if (load) begin
         s_ready[ptr_q] = 1'b1;
      end
   end

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_vfid_d  = m_vfid_q;
      if (load) begin
         m_valid_d = 1'b1;
         m_data_d  = data_a[ptr_q];
         m_vfid_d  = ptr_q;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= ST_SELECT;
         ptr_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_vfid_q  <= '0;
         for (int i = 0; i < N_REGIONS; i++) begin
            def_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_vfid_q  <= m_vfid_d;
         for (int i = 0; i < N_REGIONS; i++) begin
            def_q[i] <= def_d[i];
         end
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_vfid  = m_vfid_q;

`ifdef RDMA_TX_SCHED_STATS_EN
   logic [31:0] cnt_q [N_REGIONS];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N_REGIONS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REGIONS; i++) begin
            if (s_valid[i] && s_ready[i]) begin
               cnt_q[i] <= cnt_q[i] + 32'd1;
            end
         end
      end
   end

   genvar s;
   generate
      for (s = 0; s < N_REGIONS; s++) begin : g_stat
         assign stat_cnt[s*32 +: 32] = cnt_q[s];
      end
   endgenerate
`else
   assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_rdma_meta_tx_drr_sched.sv
// tb/tb_rdma_meta_tx_drr_sched.sv - directed self-checking bench for rdma_meta_tx_drr_sched
module tb_rdma_meta_tx_drr_sched;
   localparam int N  = 4;
   localparam int DW = 256;
   localparam int LW = 32;
   localparam int QW = 16;
   localparam int VW = 2;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_ready;
   logic [N*DW-1:0] s_data;
   logic [N*LW-1:0] s_len;
   logic [N*QW-1:0] quantum;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_data;
   logic [VW-1:0]   m_vfid;
   logic [N*32-1:0] stat_cnt;

   int n_cmp = 0;
   int n_mis = 0;
   int rem[N];
   int len[N];
   int seq[N];
   int acc_cnt[N];
   int tick_no;
   int first_acc_tick;
   int first_acc_r;
   int out_r[$];
   int out_t[$];
   logic          pend_v;
   logic [DW-1:0] pend_d;
   logic [VW-1:0] pend_r;
   logic [N-1:0]  smp_ready;
   logic          smp_mv;
   logic [DW-1:0] smp_md;
   logic [VW-1:0] smp_vf;

   always #5 aclk = ~aclk;

   rdma_meta_tx_drr_sched #(
      .N_REGIONS(N), .DATA_BITS(DW), .LEN_BITS(LW), .Q_BITS(QW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_len(s_len),
      .quantum(quantum),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_vfid(m_vfid),
      .stat_cnt(stat_cnt)
   );

   function automatic logic [DW-1:0] mk(input int r, input int s);
      logic [7:0]  rb;
      logic [15:0] sb;
      rb = 8'(r);
      sb = 16'(s);
      return {{(DW-24){1'b0}}, rb, sb};
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_src();
      for (int i = 0; i < N; i++) begin
         s_valid[i]         = (rem[i] > 0);
         s_len[i*LW +: LW]  = LW'(len[i]);
         s_data[i*DW +: DW] = mk(i, seq[i]);
      end
   endtask

   task automatic set_q(input int r, input int q);
      quantum[r*QW +: QW] = QW'(q);
   endtask

   task automatic tick();
      logic [N-1:0] acc;
      @(negedge aclk);
      smp_ready = s_ready;
      smp_mv    = m_valid;
      smp_md    = m_data;
      smp_vf    = m_vfid;
      chk("ready_onehot0", $onehot0(s_ready), 1'b1);
      chk("ready_needs_valid", s_ready & ~s_valid, '0);
      if (pend_v) begin
         chk("lat_valid", m_valid, 1'b1);
         chk("lat_data", m_data, pend_d);
         chk("lat_vfid", m_vfid, pend_r);
      end
      acc    = s_valid & s_ready;
      pend_v = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            pend_v = 1'b1;
            pend_d = mk(i, seq[i]);
            pend_r = VW'(i);
            acc_cnt[i]++;
            if (first_acc_tick < 0) begin
               first_acc_tick = tick_no;
               first_acc_r    = i;
            end
         end
      end
      if (m_valid && m_ready) begin
         out_r.push_back(int'(m_vfid));
         out_t.push_back(tick_no);
      end
      @(posedge aclk);
      #1;
      tick_no++;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            rem[i]--;
            seq[i]++;
         end
      end
      apply_src();
   endtask

   task automatic start_reset();
      aresetn = 1'b0;
      m_ready = 1'b0;
      quantum = '0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; len[i] = 0; seq[i] = 0; acc_cnt[i] = 0;
      end
      apply_src();
      pend_v = 1'b0;
      out_r.delete();
      out_t.delete();
      first_acc_tick = -1;
      first_acc_r    = -1;
      repeat (2) @(posedge aclk);
      #1;
      tick_no = 0;
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_data", m_data, '0);
      chk("rst_m_vfid", m_vfid, '0);
      chk("rst_s_ready", s_ready, '0);
      chk("rst_stat_cnt", stat_cnt, '0);
   endtask

   task automatic run_out(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (out_r.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, out_r.size() >= n, 1'b1);
   endtask

   task automatic run_acc(input string tag, input int r, input int budget);
      int k;
      k = 0;
      while (acc_cnt[r] == 0 && k < budget) begin
         tick();
         k++;
      end
      chk(tag, acc_cnt[r] > 0, 1'b1);
   endtask

   initial begin
      int exp1[8];
      int c[N];

      // two regions, equal quantum, 512 B commands
      start_reset();
      for (int i = 0; i < N; i++) set_q(i, 1024);
      rem[0] = 1000; len[0] = 512;
      rem[1] = 1000; len[1] = 512;
      apply_src();
      m_ready = 1'b1;
      aresetn = 1'b1;
      run_out("t1_count", 8, 100);
      exp1 = '{0, 0, 1, 1, 0, 0, 1, 1};
      for (int k = 0; k < 8; k++) chk($sformatf("t1_vfid_%0d", k), out_r[k], exp1[k]);
      chk("t1_time0", out_t[0], 2);
      chk("t1_time1", out_t[1], 3);
      chk("t1_time2", out_t[2], 6);
      chk("t1_time3", out_t[3], 7);
      chk("t1_time4", out_t[4], 12);
`ifdef RDMA_TX_SCHED_STATS_EN
      chk("t1_stat0", stat_cnt[31:0], acc_cnt[0]);
      chk("t1_stat1", stat_cnt[63:32], acc_cnt[1]);
`else
      chk("t1_stat_off", stat_cnt, '0);
`endif

      // 4:1 byte-quantum ratio
      start_reset();
      set_q(0, 2048); set_q(1, 512); set_q(2, 512); set_q(3, 512);
      rem[0] = 1000; len[0] = 512;
      rem[1] = 1000; len[1] = 512;
      apply_src();
      m_ready = 1'b1;
      aresetn = 1'b1;
      run_out("t2_count", 100, 1000);
      c[0] = 0;
      for (int k = 0; k < 100; k++) if (out_r[k] == 0) c[0]++;
      chk("t2_ratio_r0", (c[0] >= 79 && c[0] <= 81), 1'b1);
      chk("t2_first5", {out_r[0][1:0], out_r[3][1:0], out_r[4][1:0], out_r[5][1:0]}, 8'b00_00_01_00);

      // single large command accumulates deficit over four visits
      start_reset();
      for (int i = 0; i < N; i++) set_q(i, 1024);
      rem[0] = 1; len[0] = 4096;
      apply_src();
      m_ready = 1'b1;
      aresetn = 1'b1;
      run_acc("t3_granted", 0, 40);
      chk("t3_grant_cycle", first_acc_tick, 16);
      tick();
      chk("t3_out_valid", smp_mv, 1'b1);
      chk("t3_out_data", smp_md, mk(0, 0));
      repeat (10) tick();
      chk("t3_idle_valid", smp_mv, 1'b0);
      chk("t3_idle_ready", smp_ready, '0);

      // back-pressure holds the output register
      start_reset();
      set_q(0, 1024);
      rem[0] = 3; len[0] = 256;
      apply_src();
      m_ready = 1'b0;
      aresetn = 1'b1;
      run_acc("t4_granted", 0, 20);
      chk("t4_grant_cycle", first_acc_tick, 1);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t4_hold_valid", smp_mv, 1'b1);
         chk("t4_hold_data", smp_md, mk(0, 0));
         chk("t4_hold_vfid", smp_vf, '0);
         chk("t4_hold_ready", smp_ready, '0);
      end
      m_ready = 1'b1;
      tick();
      chk("t4_resume_ready", smp_ready, 4'b0001);
      chk("t4_resume_data", smp_md, mk(0, 0));
      tick();
      chk("t4_next_data", smp_md, mk(0, 1));

      // disabled region never granted, others share equally
      start_reset();
      set_q(0, 512); set_q(1, 0); set_q(2, 512); set_q(3, 512);
      for (int i = 0; i < N; i++) begin
         rem[i] = 1000; len[i] = 512;
      end
      apply_src();
      m_ready = 1'b1;
      aresetn = 1'b1;
      run_out("t5_count", 60, 600);
      for (int i = 0; i < N; i++) c[i] = 0;
      for (int k = 0; k < 60; k++) c[out_r[k] & 3]++;
      chk("t5_r0", c[0], 20);
      chk("t5_r1", c[1], 0);
      chk("t5_r2", c[2], 20);
      chk("t5_r3", c[3], 20);

      // asynchronous reset while a command is pending on the output
      start_reset();
      for (int i = 0; i < N; i++) set_q(i, 1024);
      rem[1] = 5; len[1] = 256;
      apply_src();
      m_ready = 1'b0;
      aresetn = 1'b1;
      run_acc("t6_granted", 1, 20);
      chk("t6_grant_cycle", first_acc_tick, 2);
      tick();
      chk("t6_pend_valid", smp_mv, 1'b1);
      chk("t6_pend_vfid", smp_vf, 2'd1);
      aresetn = 1'b0;
      #1;
      chk("t6_async_valid", m_valid, 1'b0);
      chk("t6_async_data", m_data, '0);
      chk("t6_async_vfid", m_vfid, '0);
      chk("t6_async_ready", s_ready, '0);
      chk("t6_async_stat", stat_cnt, '0);
      rem[0] = 5; len[0] = 256;
      apply_src();
      pend_v = 1'b0;
      first_acc_tick = -1;
      first_acc_r    = -1;
      for (int i = 0; i < N; i++) acc_cnt[i] = 0;
      @(posedge aclk);
      #1;
      tick_no = 0;
      m_ready = 1'b1;
      aresetn = 1'b1;
      run_acc("t6_regrant", 0, 20);
      chk("t6_first_region", first_acc_r, 0);
      chk("t6_first_cycle", first_acc_tick, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
